// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: opcodes, bubble instruction, datapath width
// and immediate-format classification used by the ID stage.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, LOAD, JALR: return IMM_I;
            STORE:              return IMM_S;
            BRANCH:             return IMM_B;
            LUI, AUIPC:         return IMM_U;
            JAL:                return IMM_J;
            default:            return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/id_cycle_reg_file.sv
// 32 x XLEN integer register file: two read ports, one write port, x0 tied
// to zero, and write-through so a same-cycle WB value is visible to readers.
import riscv_pkg::*;

module reg_file (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [1:NREGS-1];
    logic            wr_en;

    assign wr_en = we && (waddr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass lets the ID stage see a value that WB commits on this same edge.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rs1 != 5'd0) begin
            rdata1 = (wr_en && waddr == rs1) ? wdata : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rdata2 = (wr_en && waddr == rs2) ? wdata : regs[rs2];
        end
    end

endmodule

// File: rtl/id_cycle.sv
// RISC-V ID stage: register read, immediate generation, ID/EX register.
// Load-use stall detection is built only when ID_HAZARD_DETECT_EN is defined.
import riscv_pkg::*;

module id_cycle (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] NPC,
    input  logic [31:0]     IR,
    input  logic            EX_MEM_Cond,
    input  logic            WB_RegWrite,
    input  logic [4:0]      WB_rd,
    input  logic [XLEN-1:0] WB_data,
    output logic            stall,
    output logic [XLEN-1:0] ID_EX_NPC,
    output logic [31:0]     ID_EX_IR,
    output logic [XLEN-1:0] ID_EX_A,
    output logic [XLEN-1:0] ID_EX_B,
    output logic [XLEN-1:0] ID_EX_Imm,
    output logic            ID_EX_MemRead,
    output logic [4:0]      ID_EX_rd
);

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic            bubble;

    assign opcode = IR[6:0];
    assign rs1    = IR[19:15];
    assign rs2    = IR[24:20];

    reg_file u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .rs1    (rs1),
        .rs2    (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (WB_RegWrite),
        .waddr  (WB_rd),
        .wdata  (WB_data)
    );

    always_comb begin
        imm = '0;
        case (imm_type_of(opcode))
            IMM_I:   imm = {{20{IR[31]}}, IR[31:20]};
            IMM_S:   imm = {{20{IR[31]}}, IR[31:25], IR[11:7]};
            IMM_B:   imm = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
            IMM_U:   imm = {IR[31:12], 12'b0};
            IMM_J:   imm = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

`ifdef ID_HAZARD_DETECT_EN
    logic uses_rs2;
    logic hazard;

    assign uses_rs2 = (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);
    assign hazard   = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == rs1) || (uses_rs2 && ID_EX_rd == rs2));
    // A flush kills the dependent instruction anyway, so never hold IF for it.
    assign stall    = hazard && !EX_MEM_Cond;
`else
    assign stall    = 1'b0;
`endif

    assign bubble = EX_MEM_Cond || stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_EX_NPC     <= '0;
            ID_EX_IR      <= NOP_INSN;
            ID_EX_A       <= '0;
            ID_EX_B       <= '0;
            ID_EX_Imm     <= '0;
            ID_EX_MemRead <= 1'b0;
            ID_EX_rd      <= 5'd0;
        end else if (bubble) begin
            ID_EX_NPC     <= '0;
            ID_EX_IR      <= NOP_INSN;
            ID_EX_A       <= '0;
            ID_EX_B       <= '0;
            ID_EX_Imm     <= '0;
            ID_EX_MemRead <= 1'b0;
            ID_EX_rd      <= 5'd0;
        end else begin
            ID_EX_NPC     <= NPC;
            ID_EX_IR      <= IR;
            ID_EX_A       <= rdata1;
            ID_EX_B       <= rdata2;
            ID_EX_Imm     <= imm;
            ID_EX_MemRead <= (opcode == LOAD);
            ID_EX_rd      <= IR[11:7];
        end
    end

endmodule
